k12a_state_sequencer: RTL and testbench

//  Parametrised successor to the CPU state register: holds the control-FSM state and adds stall, flush,

---
 rtl/k12a_state_sequencer.sv | 131 +++++++++++++
 tb/tb_k12a_state_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/k12a_state_sequencer.sv
// k12a_state_sequencer
// Holds the CPU control-FSM state register and layers stall, flush,
// interrupt entry at instruction boundaries, per-instruction cycle counting
// and a sticky hung-instruction timeout on top of the decoder's next_state.
//
// Optional build macro: K12A_STATE_TRACE_EN
//   defined   -> a TRACE_DEPTH-entry history of state changes, read through
//                trace_rd_idx / trace_data (0 = most recent change)
//   undefined -> no trace storage, trace_data reads 0
//
// Key encodings
//   state        | meaning
//   RESET_STATE  | FETCH1; entering it after a load marks an instruction boundary
//   IRQ_STATE    | interrupt entry; replaces a boundary when irq_req is pending
//   other        | decoder-owned instruction-execution states
module k12a_state_sequencer #(
  parameter int STATE_W        = 4,
  parameter int RESET_STATE    = 0,
  parameter int IRQ_STATE      = 15,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int TRACE_DEPTH    = 8,
  localparam int IDX_W         = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
  input  logic               cpu_clock,
  input  logic               reset_n,
  input  logic [STATE_W-1:0] next_state,
  input  logic               stall,
  input  logic               flush,
  input  logic               irq_req,
  output logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] prev_state,
  output logic               irq_ack,
  output logic               instr_boundary,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               timeout,
  input  logic [IDX_W-1:0]   trace_rd_idx,
  output logic [STATE_W-1:0] trace_data
);

  localparam logic [STATE_W-1:0] RST_ENC     = STATE_W'(RESET_STATE);
  localparam logic [STATE_W-1:0] IRQ_ENC     = STATE_W'(IRQ_STATE);
  localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic               load;
  logic               take_irq;
  logic [STATE_W-1:0] load_state;
  logic               entry_load;
  logic [CNT_W-1:0]   cnt_inc;

  // Next-state selection: flush beats stall beats irq beats the decoder.
  // An irq is only taken where the decoder would have returned to FETCH1.
  always_comb begin
    load       = flush | ~stall;
    take_irq   = ~flush & ~stall & irq_req & (next_state == RST_ENC);
    load_state = next_state;
    if (flush) begin
      load_state = RST_ENC;
    end else if (take_irq) begin
      load_state = IRQ_ENC;
    end
    entry_load = load & ((load_state == RST_ENC) | (load_state == IRQ_ENC));
    cnt_inc    = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + 1'b1;
  end

  // State register, entry pulses, cycle counter and sticky timeout.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RST_ENC;
      prev_state     <= RST_ENC;
      irq_ack        <= 1'b0;
      instr_boundary <= 1'b0;
      cycle_count    <= '0;
      timeout        <= 1'b0;
    end else begin
      if (load) begin
        state      <= load_state;
        prev_state <= state;
      end
      irq_ack        <= take_irq;
      instr_boundary <= load & (load_state == RST_ENC);
      if (entry_load) begin
        cycle_count <= '0;
      end else begin
        cycle_count <= cnt_inc;
      end
      // Clear wins over a coincident set; the count is only "incremented"
      // on cycles that do not restart it.
      if (flush) begin
        timeout <= 1'b0;
      end else if (!entry_load && (cnt_inc == TIMEOUT_VAL)) begin
        timeout <= 1'b1;
      end
    end
  end

`ifdef K12A_STATE_TRACE_EN
  logic [STATE_W-1:0] trace_mem [TRACE_DEPTH];
  logic [IDX_W-1:0]   wr_ptr;
  logic               trace_wr;
  logic [IDX_W-1:0]   rd_addr;

  // Only real state changes are logged; repeat loads and stalls are not.
  always_comb begin
    trace_wr = load & (load_state != state);
    rd_addr  = wr_ptr - IDX_W'(1) - trace_rd_idx;
  end

  // Circular history buffer; cleared on reset so unwritten entries read 0.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        trace_mem[i] <= '0;
      end
    end else if (trace_wr) begin
      trace_mem[wr_ptr] <= load_state;
      wr_ptr            <= wr_ptr + IDX_W'(1);
    end
  end

  assign trace_data = trace_mem[rd_addr];
`else
  logic unused_trace_idx;

  assign unused_trace_idx = ^trace_rd_idx;
  assign trace_data       = '0;
`endif

endmodule

// File: tb/tb_k12a_state_sequencer.sv
// Bench for k12a_state_sequencer: table of per-cycle vectors fed through an
// expected-result queue, plus hand-written reset and trace sequences.
module tb_k12a_state_sequencer;

  logic       cpu_clock;
  logic       reset_n;
  logic [3:0] next_state;
  logic       stall;
  logic       flush;
  logic       irq_req;
  logic [3:0] state;
  logic [3:0] prev_state;
  logic       irq_ack;
  logic       instr_boundary;
  logic [2:0] cycle_count;
  logic       timeout;
  logic [2:0] trace_rd_idx;
  logic [3:0] trace_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       fl;
    logic       st;
    logic       irq;
    logic [3:0] nxt;
    logic [3:0] e_state;
    logic [3:0] e_prev;
    logic       e_ack;
    logic       e_bnd;
    logic [2:0] e_cnt;
    logic       e_to;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs [NVEC];
  vec_t exp_q [$];

  k12a_state_sequencer #(
    .STATE_W(4), .RESET_STATE(0), .IRQ_STATE(15), .CNT_W(3),
    .TIMEOUT_CYCLES(4), .TRACE_DEPTH(8)
  ) dut (
    .cpu_clock(cpu_clock), .reset_n(reset_n), .next_state(next_state),
    .stall(stall), .flush(flush), .irq_req(irq_req), .state(state),
    .prev_state(prev_state), .irq_ack(irq_ack), .instr_boundary(instr_boundary),
    .cycle_count(cycle_count), .timeout(timeout), .trace_rd_idx(trace_rd_idx),
    .trace_data(trace_data)
  );

  initial cpu_clock = 1'b0;
  always #5 cpu_clock = ~cpu_clock;

  function automatic vec_t mk(input logic fl, input logic st, input logic irq,
                              input logic [3:0] nxt, input logic [3:0] es,
                              input logic [3:0] ep, input logic ea, input logic eb,
                              input logic [2:0] ec, input logic et);
    vec_t v;
    v.fl = fl; v.st = st; v.irq = irq; v.nxt = nxt;
    v.e_state = es; v.e_prev = ep; v.e_ack = ea; v.e_bnd = eb;
    v.e_cnt = ec; v.e_to = et;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_and_check(input int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      chk($sformatf("scoreboard_empty[%0d]", idx), 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("state[%0d]", idx), int'(state), int'(e.e_state));
    chk($sformatf("prev_state[%0d]", idx), int'(prev_state), int'(e.e_prev));
    chk($sformatf("irq_ack[%0d]", idx), int'(irq_ack), int'(e.e_ack));
    chk($sformatf("instr_boundary[%0d]", idx), int'(instr_boundary), int'(e.e_bnd));
    chk($sformatf("cycle_count[%0d]", idx), int'(cycle_count), int'(e.e_cnt));
    chk($sformatf("timeout[%0d]", idx), int'(timeout), int'(e.e_to));
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge cpu_clock);
    flush = v.fl; stall = v.st; irq_req = v.irq; next_state = v.nxt;
    exp_q.push_back(v);
    @(posedge cpu_clock);
    #1;
    pop_and_check(idx);
  endtask

  task automatic drv(input logic fl, input logic st, input logic irq, input logic [3:0] nxt);
    @(negedge cpu_clock);
    flush = fl; stall = st; irq_req = irq; next_state = nxt;
    @(posedge cpu_clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_prev"}, int'(prev_state), 0);
    chk({tag, "_cnt"}, int'(cycle_count), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_ack"}, int'(irq_ack), 0);
    chk({tag, "_bnd"}, int'(instr_boundary), 0);
  endtask

  initial begin
    //               fl st irq nxt  st  prv ack bnd cnt to
    vecs[0]  = mk(0, 0, 0, 1,  1,  0,  0, 0, 1, 0);
    vecs[1]  = mk(0, 0, 0, 2,  2,  1,  0, 0, 2, 0);
    vecs[2]  = mk(0, 1, 0, 0,  2,  1,  0, 0, 3, 0);
    vecs[3]  = mk(0, 1, 0, 0,  2,  1,  0, 0, 4, 1);
    vecs[4]  = mk(0, 0, 0, 0,  0,  2,  0, 1, 0, 1);
    vecs[5]  = mk(1, 0, 0, 7,  0,  0,  0, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 2,  2,  0,  0, 0, 1, 0);
    vecs[7]  = mk(0, 1, 1, 0,  2,  0,  0, 0, 2, 0);
    vecs[8]  = mk(0, 0, 1, 0,  15, 2,  1, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 3,  3,  15, 0, 0, 1, 0);
    vecs[10] = mk(1, 0, 1, 4,  0,  3,  0, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 1,  1,  0,  0, 0, 1, 0);
    vecs[12] = mk(0, 0, 1, 0,  15, 1,  1, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0,  0,  15, 0, 1, 0, 0);
    vecs[14] = mk(0, 0, 0, 0,  0,  0,  0, 1, 0, 0);
    vecs[15] = mk(0, 0, 0, 5,  5,  0,  0, 0, 1, 0);
    vecs[16] = mk(0, 0, 0, 5,  5,  5,  0, 0, 2, 0);
    vecs[17] = mk(0, 0, 0, 5,  5,  5,  0, 0, 3, 0);
    vecs[18] = mk(0, 0, 0, 5,  5,  5,  0, 0, 4, 1);
    vecs[19] = mk(0, 0, 0, 5,  5,  5,  0, 0, 5, 1);
    vecs[20] = mk(0, 0, 0, 5,  5,  5,  0, 0, 6, 1);
    vecs[21] = mk(0, 0, 0, 5,  5,  5,  0, 0, 7, 1);
    vecs[22] = mk(0, 0, 0, 5,  5,  5,  0, 0, 7, 1);
    vecs[23] = mk(0, 0, 0, 0,  0,  5,  0, 1, 0, 1);
    vecs[24] = mk(0, 0, 0, 5,  5,  0,  0, 0, 1, 1);
    vecs[25] = mk(1, 0, 0, 5,  0,  5,  0, 1, 0, 0);
    vecs[26] = mk(0, 0, 0, 6,  6,  0,  0, 0, 1, 0);
    vecs[27] = mk(1, 1, 1, 0,  0,  6,  0, 1, 0, 0);
    vecs[28] = mk(0, 0, 0, 15, 15, 0,  0, 0, 0, 0);
    vecs[29] = mk(0, 0, 0, 0,  0,  15, 0, 1, 0, 0);

    reset_n = 1'b0; next_state = 4'd0; stall = 1'b0; flush = 1'b0;
    irq_req = 1'b0; trace_rd_idx = 3'd0;
    #2;
    check_reset_values("por");
    @(negedge cpu_clock);
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i], i);
    end

    // Reset asserted mid-instruction with the timeout already set.
    for (int i = 0; i < 4; i++) drv(0, 0, 0, 4'd5);
    chk("pre_reset_timeout", int'(timeout), 1);
    chk("pre_reset_state", int'(state), 5);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    irq_req = 1'b1; next_state = 4'd0;
    @(posedge cpu_clock);
    #1;
    chk("rst_irq_ack", int'(irq_ack), 0);
    chk("rst_irq_state", int'(state), 0);
    @(negedge cpu_clock);
    irq_req = 1'b0;
    reset_n = 1'b1;

`ifdef K12A_STATE_TRACE_EN
    for (int k = 0; k < 8; k++) begin
      trace_rd_idx = 3'(k);
      #1;
      chk($sformatf("trace_empty[%0d]", k), int'(trace_data), 0);
    end
    drv(0, 0, 0, 4'd1);
    drv(0, 0, 0, 4'd1);
    drv(0, 0, 0, 4'd2);
    drv(0, 1, 0, 4'd9);
    drv(0, 0, 0, 4'd3);
    trace_rd_idx = 3'd0; #1;
    chk("trace_partial_idx0", int'(trace_data), 3);
    trace_rd_idx = 3'd2; #1;
    chk("trace_partial_idx2", int'(trace_data), 1);
    trace_rd_idx = 3'd3; #1;
    chk("trace_partial_idx3", int'(trace_data), 0);
    drv(0, 0, 0, 4'd4);
    drv(0, 0, 0, 4'd4);
    for (int s = 5; s <= 10; s++) drv(0, 0, 0, 4'(s));
    for (int k = 0; k < 8; k++) begin
      trace_rd_idx = 3'(k);
      #1;
      chk($sformatf("trace_full[%0d]", k), int'(trace_data), 10 - k);
    end
`else
    drv(0, 0, 0, 4'd1);
    drv(0, 0, 0, 4'd2);
    for (int k = 0; k < 8; k++) begin
      trace_rd_idx = 3'(k);
      #1;
      chk($sformatf("trace_off[%0d]", k), int'(trace_data), 0);
    end
`endif

    if (exp_q.size() != 0) chk("scoreboard_leftover", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
